// File: rtl/ecc_scrub_mem.sv
// ecc_scrub_mem: SECDED-protected register-file memory with a background scrubber.
//   Writes are Hamming+overall-parity encoded; reads are decoded/corrected with 1-cycle latency.
//   The scrub FSM (WAIT/READ/CHECK/WB) walks addresses and rewrites single-error words.
// Ports: clk/rst (sync, active-high); write port wr_en/wr_addr/wr_data with
//   inject_1_error/inject_2_error; read port rd_en/rd_addr -> rd_data/rd_valid/
//   rd_single_err/rd_double_err/rd_syndrome; scrub_en/scrub_busy; ce_count/ue_count (saturating).
module ecc_scrub_mem #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 64,
  // Smallest P with 2^P >= DATA_W+P+1.
  localparam int P = (DATA_W + 4 <= 8)    ? 3 :
                     (DATA_W + 5 <= 16)   ? 4 :
                     (DATA_W + 6 <= 32)   ? 5 :
                     (DATA_W + 7 <= 64)   ? 6 :
                     (DATA_W + 8 <= 128)  ? 7 :
                     (DATA_W + 9 <= 256)  ? 8 :
                     (DATA_W + 10 <= 512) ? 9 : 10,
  localparam int CODE_W = DATA_W + P + 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inject_1_error,
  input  logic              inject_2_error,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_single_err,
  output logic              rd_double_err,
  output logic [P:0]        rd_syndrome,
  input  logic              scrub_en,
  output logic              scrub_busy,
  output logic [15:0]       ce_count,
  output logic [15:0]       ue_count
);

  localparam int CNT_W = $clog2(SCRUB_INTERVAL);

  // Data bits occupy the non-power-of-two positions from 3 upward; position 0 is overall parity.
  function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    logic              p;
    int                di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[di];
        di++;
      end
    end
    for (int k = 0; k < P; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < CODE_W; pos++) begin
        if ((((pos >> k) & 1) != 0) && (pos != (1 << k))) p = p ^ cw[pos];
      end
      cw[1 << k] = p;
    end
    cw[0] = ^cw[CODE_W-1:1];
    return cw;
  endfunction

  // Returns {overall_parity, hamming_syndrome}.
  function automatic logic [P:0] f_syndrome(input logic [CODE_W-1:0] cw);
    logic [P:0] s;
    s = '0;
    for (int k = 0; k < P; k++) begin
      for (int pos = 1; pos < CODE_W; pos++) begin
        if (((pos >> k) & 1) != 0) s[k] = s[k] ^ cw[pos];
      end
    end
    s[P] = ^cw;
    return s;
  endfunction

  // A syndrome pointing past the codeword cannot be a real single flip.
  function automatic logic f_single(input logic [P:0] s);
    return s[P] && (int'(s[P-1:0]) < CODE_W);
  endfunction

  function automatic logic f_double(input logic [P:0] s);
    return (!s[P] && (s[P-1:0] != '0)) || (s[P] && (int'(s[P-1:0]) >= CODE_W));
  endfunction

  // Corrected data field; doubles come back uncorrected.
  function automatic logic [DATA_W-1:0] f_data(input logic [CODE_W-1:0] cw, input logic [P:0] s);
    logic [CODE_W-1:0] fix;
    logic [DATA_W-1:0] d;
    int                di;
    fix = cw;
    for (int pos = 0; pos < CODE_W; pos++) begin
      if (f_single(s) && (int'(s[P-1:0]) == pos)) fix[pos] = ~fix[pos];
    end
    d  = '0;
    di = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[di] = fix[pos];
        di++;
      end
    end
    return d;
  endfunction

  typedef enum logic [1:0] {S_WAIT, S_READ, S_CHECK, S_WB} state_t;

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid, r_rd_single, r_rd_double;
  logic [P:0]        r_rd_syn;
  logic [15:0]       r_ce, r_ue;
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [AW-1:0]     r_scrub_addr;
  logic [CODE_W-1:0] r_scrub_cw;
  logic [DATA_W-1:0] r_scrub_data;
  logic              r_abort, w_abort_nxt;

  logic [CODE_W-1:0] w_inj_mask, w_wr_cw, w_rd_cw, w_scrub_wr_cw;
  logic [P:0]        w_rd_syn, w_scrub_syn;
  logic              w_rd_ce, w_rd_ue, w_scrub_ce, w_scrub_ue;
  logic              w_addr_inc, w_scrub_wr, w_hit;
  logic [16:0]       w_ce_sum, w_ue_sum;

  // Double injection takes precedence over single.
  always_comb begin
    w_inj_mask = '0;
    if (inject_2_error) begin
      w_inj_mask[3] = 1'b1;
      w_inj_mask[5] = 1'b1;
    end else if (inject_1_error) begin
      w_inj_mask[3] = 1'b1;
    end
  end

  assign w_wr_cw       = f_encode(wr_data) ^ w_inj_mask;
  assign w_rd_cw       = r_mem[rd_addr];
  assign w_rd_syn      = f_syndrome(w_rd_cw);
  assign w_rd_ce       = rd_en && f_single(w_rd_syn);
  assign w_rd_ue       = rd_en && f_double(w_rd_syn);
  assign w_scrub_syn   = f_syndrome(r_scrub_cw);
  assign w_scrub_wr_cw = f_encode(r_scrub_data);
  assign w_hit         = wr_en && (wr_addr == r_scrub_addr);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_inc  = 1'b0;
    w_scrub_wr  = 1'b0;
    w_scrub_ce  = 1'b0;
    w_scrub_ue  = 1'b0;
    // A user write to the word being scrubbed makes the latched copy stale.
    w_abort_nxt = r_abort || w_hit;
    case (r_state)
      S_WAIT: begin
        w_abort_nxt = 1'b0;
        if (!scrub_en) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(SCRUB_INTERVAL - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_READ;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_READ: w_state_nxt = S_CHECK;
      S_CHECK: begin
        w_scrub_ce = f_single(w_scrub_syn);
        w_scrub_ue = f_double(w_scrub_syn);
        if (w_scrub_ce && !w_abort_nxt) begin
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_WAIT;
          w_addr_inc  = 1'b1;
        end
      end
      S_WB: begin
        if (w_abort_nxt) begin
          w_state_nxt = S_WAIT;
          w_addr_inc  = 1'b1;
        end else if (!wr_en) begin
          w_scrub_wr  = 1'b1;
          w_state_nxt = S_WAIT;
          w_addr_inc  = 1'b1;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_WAIT;
      r_cnt        <= '0;
      r_scrub_addr <= '0;
      r_scrub_cw   <= '0;
      r_scrub_data <= '0;
      r_abort      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
      if (r_state == S_READ) r_scrub_cw <= r_mem[r_scrub_addr];
      if (r_state == S_CHECK) r_scrub_data <= f_data(r_scrub_cw, w_scrub_syn);
      if (w_addr_inc) r_scrub_addr <= r_scrub_addr + 1'b1;
    end
  end

  // User write has priority; w_scrub_wr is only raised when wr_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[wr_addr] <= w_wr_cw;
    end else if (w_scrub_wr) begin
      r_mem[r_scrub_addr] <= w_scrub_wr_cw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_single <= 1'b0;
      r_rd_double <= 1'b0;
      r_rd_syn    <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data   <= f_data(w_rd_cw, w_rd_syn);
        r_rd_single <= f_single(w_rd_syn);
        r_rd_double <= f_double(w_rd_syn);
        r_rd_syn    <= w_rd_syn;
      end
    end
  end

  // User read and scrub check can both report in one cycle.
  assign w_ce_sum = {1'b0, r_ce} + 17'(w_rd_ce) + 17'(w_scrub_ce);
  assign w_ue_sum = {1'b0, r_ue} + 17'(w_rd_ue) + 17'(w_scrub_ue);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce <= '0;
      r_ue <= '0;
    end else begin
      r_ce <= w_ce_sum[16] ? 16'hFFFF : w_ce_sum[15:0];
      r_ue <= w_ue_sum[16] ? 16'hFFFF : w_ue_sum[15:0];
    end
  end

  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign rd_single_err = r_rd_single;
  assign rd_double_err = r_rd_double;
  assign rd_syndrome   = r_rd_syn;
  assign scrub_busy    = (r_state != S_WAIT);
  assign ce_count      = r_ce;
  assign ue_count      = r_ue;

endmodule

// File: tb/tb_ecc_scrub_mem.sv
// Testbench for ecc_scrub_mem: a 32-bit/4-word/interval-4 instance and an 8-bit instance.
module tb_ecc_scrub_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, inject_1_error, inject_2_error, rd_en, scrub_en;
  logic [1:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, rd_single_err, rd_double_err, scrub_busy;
  logic [6:0]  rd_syndrome;
  logic [15:0] ce_count, ue_count;

  logic        wr_en8, inj1_8, inj2_8, rd_en8, scrub_en8;
  logic [3:0]  wr_addr8, rd_addr8;
  logic [7:0]  wr_data8, rd_data8;
  logic        rd_valid8, rd_single8, rd_double8, scrub_busy8;
  logic [4:0]  rd_syn8;
  logic [15:0] ce8, ue8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ecc_scrub_mem #(.DATA_W(32), .DEPTH(4), .SCRUB_INTERVAL(4)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inject_1_error(inject_1_error), .inject_2_error(inject_2_error),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_single_err(rd_single_err), .rd_double_err(rd_double_err), .rd_syndrome(rd_syndrome),
    .scrub_en(scrub_en), .scrub_busy(scrub_busy), .ce_count(ce_count), .ue_count(ue_count)
  );

  ecc_scrub_mem #(.DATA_W(8), .DEPTH(16), .SCRUB_INTERVAL(64)) u_dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
    .inject_1_error(inj1_8), .inject_2_error(inj2_8),
    .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8), .rd_valid(rd_valid8),
    .rd_single_err(rd_single8), .rd_double_err(rd_double8), .rd_syndrome(rd_syn8),
    .scrub_en(scrub_en8), .scrub_busy(scrub_busy8), .ce_count(ce8), .ue_count(ue8)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [1:0] a, input logic [31:0] d, input logic i1, input logic i2);
    wr_en = 1'b1; wr_addr = a; wr_data = d; inject_1_error = i1; inject_2_error = i2;
    cyc();
    wr_en = 1'b0; inject_1_error = 1'b0; inject_2_error = 1'b0;
  endtask

  task automatic do_rd(input logic [1:0] a);
    rd_en = 1'b1; rd_addr = a;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    n_checks++; if ({rd_valid, rd_single_err, rd_double_err} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got=%b exp=000", {rd_valid, rd_single_err, rd_double_err}); end
    n_checks++; if (rd_syndrome !== 7'h0) begin n_errors++; $display("FAIL reset_syndrome got=%h exp=0", rd_syndrome); end
    n_checks++; if ({ce_count, ue_count} !== 32'h0) begin n_errors++; $display("FAIL reset_counts got=%h exp=0", {ce_count, ue_count}); end
    n_checks++; if (scrub_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", scrub_busy); end
    n_checks++; if ({rd_valid8, rd_data8, ce8, ue8} !== 41'h0) begin n_errors++; $display("FAIL reset_dut8 got=%h exp=0", {rd_valid8, rd_data8, ce8, ue8}); end
    rst = 1'b0;
  endtask

  task automatic test_clean();
    do_wr(2'd3, 32'h0000_0005, 1'b0, 1'b0);
    do_rd(2'd3);
    n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL clean_valid got=%b exp=1", rd_valid); end
    n_checks++; if (rd_data !== 32'h5) begin n_errors++; $display("FAIL clean_data got=%h exp=5", rd_data); end
    n_checks++; if (rd_syndrome !== 7'h0) begin n_errors++; $display("FAIL clean_syn got=%b exp=0", rd_syndrome); end
    n_checks++; if ({rd_single_err, rd_double_err} !== 2'b00) begin n_errors++; $display("FAIL clean_flags got=%b exp=00", {rd_single_err, rd_double_err}); end
    n_checks++; if ({ce_count, ue_count} !== 32'h0) begin n_errors++; $display("FAIL clean_counts got=%h exp=0", {ce_count, ue_count}); end
    cyc();
    n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL clean_valid_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_single();
    do_wr(2'd1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    do_rd(2'd1);
    n_checks++; if (rd_data !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL single_data got=%h exp=deadbeef", rd_data); end
    n_checks++; if ({rd_single_err, rd_double_err} !== 2'b10) begin n_errors++; $display("FAIL single_flags got=%b exp=10", {rd_single_err, rd_double_err}); end
    n_checks++; if (rd_syndrome !== 7'b1000011) begin n_errors++; $display("FAIL single_syn got=%b exp=1000011", rd_syndrome); end
    n_checks++; if (ce_count !== 16'd1) begin n_errors++; $display("FAIL single_ce got=%0d exp=1", ce_count); end
  endtask

  task automatic test_double();
    do_wr(2'd2, 32'h0000_0005, 1'b0, 1'b1);
    do_rd(2'd2);
    // positions 3 and 5 are data bits 0 and 1: 0x5 -> 0x6 uncorrected
    n_checks++; if ({rd_single_err, rd_double_err} !== 2'b01) begin n_errors++; $display("FAIL double_flags got=%b exp=01", {rd_single_err, rd_double_err}); end
    n_checks++; if (rd_syndrome !== 7'b0000110) begin n_errors++; $display("FAIL double_syn got=%b exp=0000110", rd_syndrome); end
    n_checks++; if (rd_data !== 32'h6) begin n_errors++; $display("FAIL double_data got=%h exp=6", rd_data); end
    n_checks++; if ({ce_count, ue_count} !== {16'd1, 16'd1}) begin n_errors++; $display("FAIL double_counts got=%h exp=00010001", {ce_count, ue_count}); end
    // both injections: double wins, data 0 -> 0x3
    do_wr(2'd0, 32'h0, 1'b1, 1'b1);
    do_rd(2'd0);
    n_checks++; if ({rd_double_err, rd_syndrome, rd_data} !== {1'b1, 7'b0000110, 32'h3}) begin n_errors++; $display("FAIL both_inject got=%b/%b/%h exp=1/0000110/3", rd_double_err, rd_syndrome, rd_data); end
    n_checks++; if (ue_count !== 16'd2) begin n_errors++; $display("FAIL both_inject_ue got=%0d exp=2", ue_count); end
  endtask

  task automatic test_same_cycle();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'h77;
    rd_en = 1'b1; rd_addr = 2'd3;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++; if (rd_data !== 32'h5) begin n_errors++; $display("FAIL same_cycle_old got=%h exp=5", rd_data); end
    do_rd(2'd3);
    n_checks++; if (rd_data !== 32'h77) begin n_errors++; $display("FAIL same_cycle_new got=%h exp=77", rd_data); end
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1; rd_addr = 2'd3;
    cyc();
    n_checks++; if ({rd_valid, rd_single_err, rd_data} !== {2'b10, 32'h77}) begin n_errors++; $display("FAIL b2b_0 got=%b%b/%h exp=10/77", rd_valid, rd_single_err, rd_data); end
    rd_addr = 2'd1;
    cyc();
    n_checks++; if ({rd_valid, rd_single_err, rd_data} !== {2'b11, 32'hDEAD_BEEF}) begin n_errors++; $display("FAIL b2b_1 got=%b%b/%h exp=11/deadbeef", rd_valid, rd_single_err, rd_data); end
    n_checks++; if (ce_count !== 16'd2) begin n_errors++; $display("FAIL b2b_ce got=%0d exp=2", ce_count); end
    rd_addr = 2'd2;
    cyc();
    rd_en = 1'b0;
    n_checks++; if ({rd_valid, rd_double_err, ue_count} !== {2'b11, 16'd3}) begin n_errors++; $display("FAIL b2b_2 got=%b%b/%0d exp=11/3", rd_valid, rd_double_err, ue_count); end
  endtask

  task automatic test_width8();
    wr_en8 = 1'b1; wr_addr8 = 4'd0; wr_data8 = 8'h3C; inj1_8 = 1'b1;
    cyc();
    wr_en8 = 1'b0; inj1_8 = 1'b0;
    rd_en8 = 1'b1; rd_addr8 = 4'd0;
    cyc();
    rd_en8 = 1'b0;
    n_checks++; if ({rd_data8, rd_single8, rd_double8} !== {8'h3C, 2'b10}) begin n_errors++; $display("FAIL w8_single got=%h/%b%b exp=3c/10", rd_data8, rd_single8, rd_double8); end
    n_checks++; if ({rd_syn8, ce8} !== {5'b10011, 16'd1}) begin n_errors++; $display("FAIL w8_syn_ce got=%b/%0d exp=10011/1", rd_syn8, ce8); end
    wr_en8 = 1'b1; wr_addr8 = 4'd1; wr_data8 = 8'h3C; inj2_8 = 1'b1;
    cyc();
    wr_en8 = 1'b0; inj2_8 = 1'b0;
    rd_en8 = 1'b1; rd_addr8 = 4'd1;
    cyc();
    rd_en8 = 1'b0;
    n_checks++; if ({rd_data8, rd_double8, rd_syn8, ue8} !== {8'h3F, 1'b1, 5'b00110, 16'd1}) begin n_errors++; $display("FAIL w8_double got=%h/%b/%b/%0d exp=3f/1/00110/1", rd_data8, rd_double8, rd_syn8, ue8); end
  endtask

  task automatic test_scrub_repair();
    logic [31:0] busy_seen;
    busy_seen = '0;
    do_reset();
    do_wr(2'd2, 32'hA5A5_A5A5, 1'b1, 1'b0);
    scrub_en = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      cyc();
      busy_seen[k] = scrub_busy;
      if (k == 17) begin
        n_checks++; if (ce_count !== 16'd0) begin n_errors++; $display("FAIL scrub_ce_pre got=%0d exp=0", ce_count); end
      end
      if (k == 18) begin
        n_checks++; if (ce_count !== 16'd1) begin n_errors++; $display("FAIL scrub_ce_check got=%0d exp=1", ce_count); end
      end
    end
    scrub_en = 1'b0;
    // visits to addr 0,1 (no error) then addr 2 with writeback
    n_checks++; if (busy_seen !== 32'h0007_0C30) begin n_errors++; $display("FAIL scrub_busy_trace got=%h exp=00070c30", busy_seen); end
    do_rd(2'd2);
    n_checks++; if ({rd_data, rd_single_err, rd_double_err, rd_syndrome} !== {32'hA5A5_A5A5, 2'b00, 7'h0}) begin n_errors++; $display("FAIL scrub_repaired got=%h/%b%b/%b exp=a5a5a5a5/00/0", rd_data, rd_single_err, rd_double_err, rd_syndrome); end
    n_checks++; if (ce_count !== 16'd1) begin n_errors++; $display("FAIL scrub_ce_final got=%0d exp=1", ce_count); end
  endtask

  task automatic test_scrub_abort();
    do_reset();
    do_wr(2'd2, 32'hA5A5_A5A5, 1'b1, 1'b0);
    scrub_en = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 18) begin
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h1234_5678;
      end
      cyc();
    end
    wr_en = 1'b0;
    n_checks++; if ({scrub_busy, ce_count} !== {1'b0, 16'd1}) begin n_errors++; $display("FAIL abort_state got=%b/%0d exp=0/1", scrub_busy, ce_count); end
    cyc();
    cyc();
    scrub_en = 1'b0;
    do_rd(2'd2);
    n_checks++; if ({rd_data, rd_single_err, rd_double_err} !== {32'h1234_5678, 2'b00}) begin n_errors++; $display("FAIL abort_data got=%h/%b%b exp=12345678/00", rd_data, rd_single_err, rd_double_err); end
  endtask

  task automatic test_reset_mid_wb();
    do_reset();
    do_wr(2'd0, 32'hA5A5_A5A5, 1'b1, 1'b0);
    scrub_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        rd_en = 1'b1; rd_addr = 2'd0;
      end
      cyc();
    end
    rd_en = 1'b0;
    // user read and scrub CHECK both report in the same cycle
    n_checks++; if ({scrub_busy, ce_count, rd_single_err} !== {1'b1, 16'd2, 1'b1}) begin n_errors++; $display("FAIL wb_pre got=%b/%0d/%b exp=1/2/1", scrub_busy, ce_count, rd_single_err); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    scrub_en = 1'b0;
    n_checks++; if ({scrub_busy, ce_count, ue_count} !== 33'h0) begin n_errors++; $display("FAIL wb_rst_state got=%b/%0d/%0d exp=0/0/0", scrub_busy, ce_count, ue_count); end
    n_checks++; if ({rd_data, rd_valid, rd_single_err, rd_double_err, rd_syndrome} !== 42'h0) begin n_errors++; $display("FAIL wb_rst_rd got=%h/%b%b%b/%b exp=0", rd_data, rd_valid, rd_single_err, rd_double_err, rd_syndrome); end
    cyc();
    cyc();
    do_rd(2'd0);
    n_checks++; if ({rd_data, rd_single_err, rd_double_err} !== {32'h0, 2'b00}) begin n_errors++; $display("FAIL wb_rst_nowrite got=%h/%b%b exp=0/00", rd_data, rd_single_err, rd_double_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    do_wr(2'd1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    rd_en = 1'b1; rd_addr = 2'd1;
    repeat (65534) cyc();
    n_checks++; if (ce_count !== 16'hFFFE) begin n_errors++; $display("FAIL sat_pre got=%h exp=fffe", ce_count); end
    cyc();
    n_checks++; if (ce_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_reach got=%h exp=ffff", ce_count); end
    cyc();
    rd_en = 1'b0;
    n_checks++; if (ce_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold got=%h exp=ffff", ce_count); end
    n_checks++; if (ue_count !== 16'h0) begin n_errors++; $display("FAIL sat_ue got=%h exp=0", ue_count); end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; inject_1_error = 1'b0; inject_2_error = 1'b0;
    rd_en = 1'b0; rd_addr = '0; scrub_en = 1'b0;
    wr_en8 = 1'b0; wr_addr8 = '0; wr_data8 = '0; inj1_8 = 1'b0; inj2_8 = 1'b0;
    rd_en8 = 1'b0; rd_addr8 = '0; scrub_en8 = 1'b0;
    #1;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_same_cycle();
    test_back_to_back();
    test_width8();
    test_scrub_repair();
    test_scrub_abort();
    test_reset_mid_wb();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
